// File: rtl/pong_match_ctrl.sv
// Match sequencing for the pong game: frame tick from vsync, button debounce,
// and the ATTRACT/READY/PLAY/PAUSED/POINT/OVER state machine.
module pong_match_ctrl #(
   parameter logic [7:0] SERVE_FRAMES = 8'd50,
   parameter logic [7:0] POINT_FRAMES = 8'd25,
   parameter logic [7:0] OVER_FRAMES  = 8'd250,
   parameter logic [3:0] WIN_SCORE    = 4'd15
) (
   input  logic       glb_clk,
   input  logic       reset_n,
   input  logic       pixtick,
   input  logic       vsync,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic [1:0] mode_sel,
   input  logic [3:0] l_score,
   input  logic [3:0] r_score,
   output logic       game_reset,
   output logic       game_pause,
   output logic       lbat_human,
   output logic       rbat_human,
   output logic [2:0] state,
   output logic       blink
);

   typedef enum logic [2:0] {
      ST_ATTRACT = 3'd0,
      ST_READY   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_POINT   = 3'd4,
      ST_OVER    = 3'd5
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] frame_cnt_reg;
   logic       game_reset_reg;
   logic       lbat_human_reg, rbat_human_reg;
   logic       vs_prev_reg;
   logic [7:0] score_prev_reg;
   logic       frame_tick;
   logic       win, score_chg;
   logic [1:0] btn_raw, press;
   logic       start_press, pause_press;

   // Previous sample resets low so a fresh falling edge is needed after reset.
   always_ff @(posedge glb_clk or negedge reset_n) begin
      if (!reset_n)
         vs_prev_reg <= 1'b0;
      else if (pixtick)
         vs_prev_reg <= vsync;
   end

   assign frame_tick = pixtick & vs_prev_reg & ~vsync;

   assign btn_raw = {pause_btn, start_btn};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic sync1_reg, sync2_reg, samp_reg, deb_reg;

         always_ff @(posedge glb_clk or negedge reset_n) begin
            if (!reset_n) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               samp_reg  <= 1'b0;
               deb_reg   <= 1'b0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               if (frame_tick) begin
                  samp_reg <= sync2_reg;
                  if (sync2_reg == samp_reg)
                     deb_reg <= sync2_reg;
               end
            end
         end

         // Press fires on the frame where the debounced level is about to rise.
         assign press[gi] = frame_tick & (sync2_reg == samp_reg) & sync2_reg & ~deb_reg;
      end
   endgenerate

   assign start_press = press[0];
   assign pause_press = press[1];

   always_ff @(posedge glb_clk or negedge reset_n) begin
      if (!reset_n)
         score_prev_reg <= 8'd0;
      else if (frame_tick)
         score_prev_reg <= {l_score, r_score};
   end

   assign score_chg = ({l_score, r_score} != score_prev_reg);
   assign win       = (l_score == WIN_SCORE) | (r_score == WIN_SCORE);

   always_comb begin
      state_next = state_reg;
      game_pause = 1'b0;
      blink      = 1'b0;
      case (state_reg)
         ST_ATTRACT: begin
            if (frame_tick && start_press)
               state_next = ST_READY;
         end
         ST_READY: begin
            game_pause = 1'b1;
            if (frame_tick && frame_cnt_reg == SERVE_FRAMES - 8'd1)
               state_next = ST_PLAY;
         end
         ST_PLAY: begin
            if (frame_tick) begin
               if (win)
                  state_next = ST_OVER;
               else if (start_press)
                  state_next = ST_READY;
               else if (pause_press)
                  state_next = ST_PAUSED;
               else if (score_chg)
                  state_next = ST_POINT;
            end
         end
         ST_PAUSED: begin
            game_pause = 1'b1;
            if (frame_tick) begin
               if (start_press)
                  state_next = ST_READY;
               else if (pause_press)
                  state_next = ST_PLAY;
            end
         end
         ST_POINT: begin
            game_pause = 1'b1;
            if (frame_tick) begin
               if (win)
                  state_next = ST_OVER;
               else if (frame_cnt_reg == POINT_FRAMES - 8'd1)
                  state_next = ST_PLAY;
            end
         end
         ST_OVER: begin
            game_pause = 1'b1;
            blink      = frame_cnt_reg[4];
            if (frame_tick && (start_press || frame_cnt_reg == OVER_FRAMES - 8'd1))
               state_next = ST_ATTRACT;
         end
         default: state_next = ST_ATTRACT;
      endcase
   end

   always_ff @(posedge glb_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_ATTRACT;
         frame_cnt_reg  <= 8'd0;
         game_reset_reg <= 1'b0;
         lbat_human_reg <= 1'b0;
         rbat_human_reg <= 1'b0;
      end else if (frame_tick) begin
         state_reg <= state_next;
         if (state_next != state_reg) begin
            frame_cnt_reg  <= 8'd0;
            game_reset_reg <= (state_next == ST_READY) || (state_next == ST_ATTRACT);
            if (state_next == ST_READY) begin
               lbat_human_reg <= mode_sel[0];
               rbat_human_reg <= mode_sel[1];
            end else if (state_next == ST_ATTRACT) begin
               lbat_human_reg <= 1'b0;
               rbat_human_reg <= 1'b0;
            end
         end else begin
            game_reset_reg <= 1'b0;
            if (frame_cnt_reg != 8'hFF)
               frame_cnt_reg <= frame_cnt_reg + 8'd1;
         end
      end
   end

   assign state      = state_reg;
   assign game_reset = game_reset_reg;
   assign lbat_human = lbat_human_reg;
   assign rbat_human = rbat_human_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: frame-level reference model of the match rules,
// directed scenarios followed by randomized button/score traffic.
module tb_pong_match_ctrl;

   logic       glb_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pixtick = 1'b0;
   logic       vsync = 1'b0;
   logic       start_btn = 1'b0;
   logic       pause_btn = 1'b0;
   logic [1:0] mode_sel = 2'b00;
   logic [3:0] l_score = 4'd0;
   logic [3:0] r_score = 4'd0;
   logic       game_reset, game_pause, lbat_human, rbat_human, blink;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   // Reference model state, advanced once per video frame
   int         m_state, m_cnt;
   bit         m_gr, m_lh, m_rh;
   bit         m_deb_s, m_deb_p, m_smp_s, m_smp_p;
   logic [7:0] m_score;

   pong_match_ctrl dut (
      .glb_clk    (glb_clk),
      .reset_n    (reset_n),
      .pixtick    (pixtick),
      .vsync      (vsync),
      .start_btn  (start_btn),
      .pause_btn  (pause_btn),
      .mode_sel   (mode_sel),
      .l_score    (l_score),
      .r_score    (r_score),
      .game_reset (game_reset),
      .game_pause (game_pause),
      .lbat_human (lbat_human),
      .rbat_human (rbat_human),
      .state      (state),
      .blink      (blink)
   );

   always #5 glb_clk = ~glb_clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] out_vec();
      return {state, game_reset, game_pause, lbat_human, rbat_human, blink};
   endfunction

   function automatic logic [7:0] exp_vec();
      bit pause_e, blink_e;
      pause_e = !(m_state == 0 || m_state == 2);
      blink_e = (m_state == 5) && (((m_cnt >> 4) & 1) == 1);
      return {3'(m_state), m_gr, pause_e, m_lh, m_rh, blink_e};
   endfunction

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_gr = 0; m_lh = 0; m_rh = 0;
      m_deb_s = 0; m_deb_p = 0; m_smp_s = 0; m_smp_p = 0; m_score = 8'd0;
   endtask

   task automatic model_tick();
      bit s, p, ps, pp, chg, win;
      int nxt;
      s = start_btn;
      p = pause_btn;
      ps = (s == m_smp_s) && s && !m_deb_s;
      pp = (p == m_smp_p) && p && !m_deb_p;
      if (s == m_smp_s) m_deb_s = s;
      if (p == m_smp_p) m_deb_p = p;
      m_smp_s = s;
      m_smp_p = p;
      chg = ({l_score, r_score} != m_score);
      m_score = {l_score, r_score};
      win = (l_score == 4'd15) || (r_score == 4'd15);
      nxt = m_state;
      case (m_state)
         0: if (ps) nxt = 1;
         1: if (m_cnt == 49) nxt = 2;
         2: if (win) nxt = 5; else if (ps) nxt = 1; else if (pp) nxt = 3; else if (chg) nxt = 4;
         3: if (ps) nxt = 1; else if (pp) nxt = 2;
         4: if (win) nxt = 5; else if (m_cnt == 24) nxt = 2;
         5: if (ps || m_cnt == 249) nxt = 0;
         default: nxt = 0;
      endcase
      if (nxt != m_state) begin
         m_cnt = 0;
         m_gr = (nxt == 1) || (nxt == 0);
         if (nxt == 1) begin m_lh = mode_sel[0]; m_rh = mode_sel[1]; end
         if (nxt == 0) begin m_lh = 0; m_rh = 0; end
      end else begin
         m_gr = 0;
         if (m_cnt < 255) m_cnt++;
      end
      m_state = nxt;
   endtask

   // One video frame: vsync high for a while, then a falling edge on a pixtick
   task automatic run_frame(input bit s, input bit p, input string tag);
      start_btn = s;
      pause_btn = p;
      vsync = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge glb_clk); #1;
         pixtick = i[0];
      end
      vsync = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge glb_clk); #1;
         pixtick = i[0];
      end
      model_tick();
      check_eq(tag, out_vec(), exp_vec());
   endtask

   task automatic async_reset();
      start_btn = 1'b0;
      pause_btn = 1'b0;
      @(posedge glb_clk); #3;
      reset_n = 1'b0;
      #1;
      check_eq("async_rst", out_vec(), 8'h00);
      repeat (3) @(posedge glb_clk);
      #2;
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      bit rs, rp;
      model_reset();
      #1;
      check_eq("rst_outputs", out_vec(), 8'h00);
      repeat (4) @(posedge glb_clk);
      #2;
      reset_n = 1'b1;

      // Start held 3 frames with left human selected, then serve delay
      mode_sel = 2'b01;
      r_score = 4'd3;
      repeat (3) run_frame(1, 0, "start_hold");
      repeat (49) run_frame(0, 0, "serve");
      check_eq("serve_play", 8'(state), 8'd2);
      check_eq("humans", {6'd0, lbat_human, rbat_human}, 8'b10);

      // Point scored: 25 frozen frames then back to play
      r_score = 4'd4;
      run_frame(0, 0, "point_enter");
      check_eq("point_state", {5'd0, state}, {5'd0, 3'd4});
      check_eq("point_pause", {7'd0, game_pause}, 8'd1);
      repeat (25) run_frame(0, 0, "point_hold");
      check_eq("point_done", 8'(state), 8'd2);

      // Pause, resume, pause again, then start+pause together
      repeat (2) run_frame(0, 1, "pause1");
      check_eq("paused", 8'(state), 8'd3);
      repeat (2) run_frame(0, 0, "pause_rel");
      repeat (2) run_frame(0, 1, "resume");
      check_eq("resumed", 8'(state), 8'd2);
      repeat (2) run_frame(0, 0, "resume_rel");
      repeat (2) run_frame(0, 1, "pause2");
      repeat (2) run_frame(0, 0, "pause2_rel");
      repeat (2) run_frame(1, 1, "start_wins");
      check_eq("start_wins_st", 8'(state), 8'd1);
      repeat (52) run_frame(0, 0, "serve2");

      // Left reaches winning score; OVER lasts 250 frames
      l_score = 4'd15;
      run_frame(0, 0, "win");
      check_eq("over_state", 8'(state), 8'd5);
      repeat (249) run_frame(0, 0, "over_hold");
      check_eq("over_end_st", 8'(state), 8'd5);
      l_score = 4'd0;
      r_score = 4'd0;
      run_frame(0, 0, "over_exit");
      check_eq("attract_back", 8'(state), 8'd0);
      check_eq("attract_grst", {7'd0, game_reset}, 8'd1);

      // One-frame start glitch must be ignored
      run_frame(1, 0, "glitch");
      repeat (3) run_frame(0, 0, "glitch_after");
      check_eq("glitch_st", 8'(state), 8'd0);

      // Reset while PAUSED
      mode_sel = 2'b11;
      repeat (2) run_frame(1, 0, "start3");
      repeat (52) run_frame(0, 0, "serve3");
      repeat (2) run_frame(0, 1, "pause3");
      run_frame(0, 0, "pause3_rel");
      check_eq("pre_rst_st", 8'(state), 8'd3);
      async_reset();
      repeat (2) run_frame(1, 0, "post_rst");

      // Randomized traffic
      rs = 1'b0;
      rp = 1'b0;
      for (int n = 0; n < 700; n++) begin
         if ($urandom_range(0, 7) == 0) rs = ~rs;
         if ($urandom_range(0, 5) == 0) rp = ~rp;
         if ($urandom_range(0, 19) == 0) mode_sel = 2'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 1) l_score = 4'($urandom_range(0, 15));
            else r_score = 4'($urandom_range(0, 15));
         end
         if (m_gr) begin
            l_score = 4'd0;
            r_score = 4'd0;
         end
         if ($urandom_range(0, 249) == 0) async_reset();
         run_frame(rs, rp, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
